// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA decryption block.
//  - K_DEF          : default operand width (cipher, d, n, plain)
//  - MODMUL_CYCLES  : cycles per modular multiply (1 launch + K iterations)
//  - state_t        : top-level FSM states
//  - rsa_latency()  : accept-to-out_valid latency of a valid operation
package rsa_pkg;

  localparam int unsigned K_DEF = 8;

  localparam int unsigned MODMUL_CYCLES = K_DEF + 1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCheck = 3'd1,
    StSqr   = 3'd2,
    StMul   = 3'd3,
    StErr   = 3'd4,
    StDone  = 3'd5
  } state_t;

  // Accept edge -> CHECK -> 2K multiplies of (K+1) cycles -> DONE.
  function automatic int unsigned rsa_latency(input int unsigned k);
    return 2 * k * (k + 1) + 2;
  endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier: p = (a * b) mod n.
// Ports:
//  clk   in  1  clock, rising edge
//  rst   in  1  reset, asynchronous, active-high
//  start in  1  launch a multiply; ignored while one is running
//  a     in  K  multiplicand, must be < n
//  b     in  K  multiplier, scanned MSB first
//  n     in  K  modulus
//  done  out 1  one-cycle pulse, rises K cycles after the start edge
//  p     out K  product, valid while done is high and held until the next result
module rsa_modmul import rsa_pkg::*; #(
  parameter int unsigned K = K_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic [K-1:0] n,
  output logic         done,
  output logic [K-1:0] p
);

  localparam int unsigned CW = $clog2(K + 1);

  logic [K-1:0]  a_q;
  logic [K-1:0]  b_q;
  logic [K-1:0]  n_q;
  logic [K+1:0]  acc_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic [K-1:0]  p_q;

  logic [K+1:0] n_ext;
  logic [K+1:0] a_ext;
  logic [K+1:0] dbl;
  logic [K+1:0] red1;
  logic [K+1:0] add;
  logic [K+1:0] acc_next;

  // One iteration. acc < n on entry, so 2*acc < 2n and acc + a < 2n:
  // a single conditional subtract after each step restores the invariant.
  always_comb begin
    n_ext    = {2'b00, n_q};
    a_ext    = {2'b00, a_q};
    dbl      = {acc_q[K:0], 1'b0};
    red1     = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
    add      = b_q[K-1] ? (red1 + a_ext) : red1;
    acc_next = (add >= n_ext) ? (add - n_ext) : add;
  end

  // cnt_q counts remaining iterations; zero means idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      p_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (cnt_q != '0) begin
        acc_q <= acc_next;
        b_q   <= b_q << 1;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          done_q <= 1'b1;
          p_q    <= acc_next[K-1:0];
        end
      end else if (start) begin
        a_q   <= a;
        b_q   <= b;
        n_q   <= n;
        acc_q <= '0;
        cnt_q <= CW'(K);
      end
    end
  end

  assign done = done_q;
  assign p    = p_q;

endmodule

// File: rtl/rsa_decryption.sv
// Receiver-side RSA decryption: plain = cipher^d mod n, constant-time
// left-to-right square-and-multiply over all K exponent bits.
// Ports:
//  clk        in  1  clock, rising edge
//  rst        in  1  reset, asynchronous, active-high
//  in_valid   in  1  cipher/d/n valid
//  in_ready   out 1  block can accept (IDLE only)
//  cipher     in  K  ciphertext
//  d          in  K  private exponent
//  n          in  K  modulus
//  out_valid  out 1  plain/err valid, held until out_ready
//  out_ready  in  1  consumer accepts result
//  plain      out K  recovered plaintext
//  err        out 1  invalid operands (n < 2 or cipher >= n)
//  busy       out 1  exponentiation in progress
module rsa_decryption import rsa_pkg::*; #(
  parameter int unsigned K = K_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] cipher,
  input  logic [K-1:0] d,
  input  logic [K-1:0] n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] plain,
  output logic         err,
  output logic         busy
);

  localparam int unsigned IW    = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] ITop = IW'(K - 1);

  state_t        state_q;
  logic [K-1:0]  c_q;
  logic [K-1:0]  d_q;
  logic [K-1:0]  n_q;
  logic [K-1:0]  r_q;
  logic [IW-1:0] i_q;
  logic          launch_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [K-1:0]  plain_q;
  logic          err_q;
  logic          busy_q;

  logic         mm_start;
  logic [K-1:0] mm_a;
  logic [K-1:0] mm_b;
  logic         mm_done;
  logic [K-1:0] mm_p;
  logic [K-1:0] r_next;

  // The multiply result is always computed; the exponent bit only decides
  // whether it is kept, so timing does not depend on d.
  assign r_next = d_q[i_q] ? mm_p : r_q;

  // The next multiply is launched in the same cycle the previous one reports
  // done, with operands forwarded from its result, so each multiply costs
  // exactly K+1 cycles back to back.
  always_comb begin
    mm_start = launch_q;
    mm_a     = r_q;
    mm_b     = r_q;
    if (mm_done) begin
      if (state_q == StSqr) begin
        mm_start = 1'b1;
        mm_a     = mm_p;
        mm_b     = c_q;
      end else if (state_q == StMul && i_q != '0) begin
        mm_start = 1'b1;
        mm_a     = r_next;
        mm_b     = r_next;
      end
    end
  end

  rsa_modmul #(
    .K(K)
  ) u_modmul (
    .clk  (clk),
    .rst  (rst),
    .start(mm_start),
    .a    (mm_a),
    .b    (mm_b),
    .n    (n_q),
    .done (mm_done),
    .p    (mm_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      c_q         <= '0;
      d_q         <= '0;
      n_q         <= '0;
      r_q         <= '0;
      i_q         <= '0;
      launch_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      plain_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      launch_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            c_q        <= cipher;
            d_q        <= d;
            n_q        <= n;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StCheck;
          end
        end
        StCheck: begin
          if (n_q < K'(2) || c_q >= n_q) begin
            state_q <= StErr;
          end else begin
            r_q      <= K'(1);
            i_q      <= ITop;
            launch_q <= 1'b1;
            state_q  <= StSqr;
          end
        end
        StSqr: begin
          if (mm_done) begin
            r_q     <= mm_p;
            state_q <= StMul;
          end
        end
        StMul: begin
          if (mm_done) begin
            r_q <= r_next;
            if (i_q == '0) begin
              plain_q     <= r_next;
              err_q       <= 1'b0;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= StDone;
            end else begin
              i_q     <= i_q - 1'b1;
              state_q <= StSqr;
            end
          end
        end
        StErr: begin
          plain_q     <= '0;
          err_q       <= 1'b1;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign plain     = plain_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rsa_decryption.sv
// Self-checking bench for rsa_decryption (K = 8).
module tb_rsa_decryption;

  localparam int VALID_LAT = 146;
  localparam int ERR_LAT   = 2;
  localparam int MAX_WAIT  = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] cipher = '0;
  logic [7:0] d = '0;
  logic [7:0] n = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] plain;
  logic       err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  rsa_decryption #(
    .K(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cipher   (cipher),
    .d        (d),
    .n        (n),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .plain    (plain),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] c;
    logic [7:0] dd;
    logic [7:0] nn;
    logic [7:0] pl;
    logic       er;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " plain"}, 32'(plain), 32'd0);
    check({tag, " err"}, 32'(err), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // One full transaction: accept, wait for result, check, then hand it off.
  task automatic run_op(input logic [7:0] c_v, input logic [7:0] d_v, input logic [7:0] n_v,
                        input logic [7:0] exp_pl, input logic exp_er, input int exp_lat,
                        input string tag);
    int   lat;
    logic ir_bad;
    @(negedge clk);
    check({tag, " in_ready before"}, 32'(in_ready), 32'd1);
    cipher   = c_v;
    d        = d_v;
    n        = n_v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cipher   = ~c_v;
    d        = ~d_v;
    n        = ~n_v;
    check({tag, " busy in check"}, 32'(busy), 32'd1);
    lat    = 0;
    ir_bad = 1'b0;
    while (!out_valid && lat < MAX_WAIT) begin
      if (in_ready) ir_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " plain"}, 32'(plain), 32'(exp_pl));
    check({tag, " err"}, 32'(err), 32'(exp_er));
    check({tag, " in_ready low while running"}, 32'(ir_bad), 32'd0);
    check({tag, " busy at result"}, 32'(busy), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " out_valid after handoff"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after handoff"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int   lat;
    int   stray;
    logic bp_bad;

    vecs[0]  = '{c: 8'd81,  dd: 8'd103, nn: 8'd143, pl: 8'd42,  er: 1'b0, lat: VALID_LAT};
    vecs[1]  = '{c: 8'd142, dd: 8'd103, nn: 8'd143, pl: 8'd142, er: 1'b0, lat: VALID_LAT};
    vecs[2]  = '{c: 8'd0,   dd: 8'd103, nn: 8'd143, pl: 8'd0,   er: 1'b0, lat: VALID_LAT};
    vecs[3]  = '{c: 8'd81,  dd: 8'd0,   nn: 8'd143, pl: 8'd1,   er: 1'b0, lat: VALID_LAT};
    vecs[4]  = '{c: 8'd2,   dd: 8'd3,   nn: 8'd15,  pl: 8'd8,   er: 1'b0, lat: VALID_LAT};
    vecs[5]  = '{c: 8'd254, dd: 8'd255, nn: 8'd255, pl: 8'd254, er: 1'b0, lat: VALID_LAT};
    vecs[6]  = '{c: 8'd7,   dd: 8'd1,   nn: 8'd11,  pl: 8'd7,   er: 1'b0, lat: VALID_LAT};
    vecs[7]  = '{c: 8'd5,   dd: 8'd2,   nn: 8'd13,  pl: 8'd12,  er: 1'b0, lat: VALID_LAT};
    vecs[8]  = '{c: 8'd0,   dd: 8'd5,   nn: 8'd1,   pl: 8'd0,   er: 1'b1, lat: ERR_LAT};
    vecs[9]  = '{c: 8'd200, dd: 8'd103, nn: 8'd143, pl: 8'd0,   er: 1'b1, lat: ERR_LAT};
    vecs[10] = '{c: 8'd143, dd: 8'd103, nn: 8'd143, pl: 8'd0,   er: 1'b1, lat: ERR_LAT};
    vecs[11] = '{c: 8'd0,   dd: 8'd1,   nn: 8'd0,   pl: 8'd0,   er: 1'b1, lat: ERR_LAT};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("after release");

    for (int v = 0; v < 12; v++) begin
      run_op(vecs[v].c, vecs[v].dd, vecs[v].nn, vecs[v].pl, vecs[v].er, vecs[v].lat,
             $sformatf("vec%0d", v));
    end

    // Backpressure: result held 10 cycles, in_valid pulses ignored.
    @(negedge clk);
    cipher = 8'd81; d = 8'd103; n = 8'd143; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp latency", 32'(lat), 32'(VALID_LAT));
    bp_bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cipher   = 8'(k);
      d        = 8'd1;
      n        = 8'd13;
      in_valid = k[0];
      @(posedge clk);
      #1;
      if (!out_valid || plain !== 8'd42 || err !== 1'b0 || in_ready !== 1'b0) bp_bad = 1'b1;
    end
    in_valid = 1'b0;
    check("bp held stable", 32'(bp_bad), 32'd0);
    check("bp plain", 32'(plain), 32'd42);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp out_valid drop", 32'(out_valid), 32'd0);
    check("bp in_ready return", 32'(in_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("bp no stray start", 32'(busy), 32'd0);

    // Reset 50 cycles into an operation.
    @(negedge clk);
    cipher = 8'd81; d = 8'd103; n = 8'd143; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("midop busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midop reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) stray++;
    end
    check("midop no result", 32'(stray), 32'd0);
    run_op(8'd81, 8'd103, 8'd143, 8'd42, 1'b0, VALID_LAT, "rerun");

    // Back-to-back with in_valid held high and out_ready high.
    @(negedge clk);
    out_ready = 1'b1;
    cipher = 8'd81; d = 8'd103; n = 8'd143; in_valid = 1'b1;
    @(posedge clk);
    #1;
    cipher = 8'd142;
    lat = 0;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b first latency", 32'(lat), 32'(VALID_LAT));
    check("b2b first plain", 32'(plain), 32'd42);
    @(posedge clk);
    #1;
    check("b2b idle between", 32'(in_ready), 32'd1);
    check("b2b valid drop", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b second accepted", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b second latency", 32'(lat), 32'(VALID_LAT));
    check("b2b second plain", 32'(plain), 32'd142);
    check("b2b second err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("b2b final idle", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
